// File: rtl/gray_seq_decoder.sv
// Gray-coded count receiver: converts, step-checks and tracks lock/wrap state.
// Optional GRAY_DIR_EN accepts single down-steps and reports Underflow.
module gray_seq_decoder #(
  parameter int WIDTH  = 3,
  parameter int WRAP_W = 8
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              In_Valid,
  input  logic [WIDTH-1:0]  Gray_In,
  input  logic              Resync,
  output logic              Out_Valid,
  output logic [WIDTH-1:0]  Bin_Out,
  output logic              Overflow,
  output logic              Underflow,
  output logic              Step_Err,
  output logic              Locked,
  output logic              Fault,
  output logic [WRAP_W-1:0] Wrap_Cnt
);

  typedef enum logic [1:0] {
    UNLOCKED = 2'd0,
    LOCKED   = 2'd1,
    FAULT    = 2'd2
  } state_e;

  localparam logic [WIDTH-1:0]  ALL1 = '1;
  localparam logic [WIDTH-1:0]  ONE  = WIDTH'(1);
  localparam logic [WRAP_W-1:0] WMAX = '1;
  localparam logic [WRAP_W-1:0] WINC = WRAP_W'(1);

  state_e            state_q, state_d;
  logic [WIDTH-1:0]  ref_q, ref_d;
  logic [WIDTH-1:0]  bin_q, bin_d;
  logic [WRAP_W-1:0] wrap_q, wrap_d;
  logic              ov_q, ov_d;
  logic              of_q, of_d;
  logic              se_q, se_d;
  logic [WIDTH-1:0]  bin_new;
  logic [WIDTH-1:0]  delta;

  // Each binary bit is the XOR of the Gray bits at and above it
  for (genvar i = 0; i < WIDTH; i++) begin : g_conv
    assign bin_new[i] = ^(Gray_In >> i);
  end

  assign delta = bin_new - ref_q;

`ifdef GRAY_DIR_EN
  logic uf_q, uf_d;
`endif

  always_comb begin
    state_d = state_q;
    ref_d   = ref_q;
    bin_d   = bin_q;
    wrap_d  = wrap_q;
    ov_d    = 1'b0;
    of_d    = 1'b0;
    se_d    = 1'b0;
`ifdef GRAY_DIR_EN
    uf_d    = 1'b0;
`endif
    if (Resync) begin
      state_d = UNLOCKED;
      wrap_d  = '0;
    end else if (In_Valid) begin
      ov_d  = 1'b1;
      ref_d = bin_new;
      bin_d = bin_new;
      case (state_q)
        UNLOCKED: state_d = LOCKED;
        LOCKED: begin
          if (delta == ONE) begin
            if (ref_q == ALL1) begin
              of_d = 1'b1;
              if (wrap_q != WMAX) wrap_d = wrap_q + WINC;
            end
          end
`ifdef GRAY_DIR_EN
          else if (delta == ALL1) begin
            uf_d = (ref_q == '0);
          end
`endif
          else if (delta != '0) begin
            se_d    = 1'b1;
            state_d = FAULT;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= UNLOCKED;
      ref_q   <= '0;
      bin_q   <= '0;
      wrap_q  <= '0;
      ov_q    <= 1'b0;
      of_q    <= 1'b0;
      se_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      ref_q   <= ref_d;
      bin_q   <= bin_d;
      wrap_q  <= wrap_d;
      ov_q    <= ov_d;
      of_q    <= of_d;
      se_q    <= se_d;
    end
  end

`ifdef GRAY_DIR_EN
  always_ff @(posedge Clk) begin
    if (Reset) uf_q <= 1'b0;
    else       uf_q <= uf_d;
  end
  assign Underflow = uf_q;
`else
  assign Underflow = 1'b0;
`endif

  assign Out_Valid = ov_q;
  assign Bin_Out   = bin_q;
  assign Overflow  = of_q;
  assign Step_Err  = se_q;
  assign Wrap_Cnt  = wrap_q;
  assign Locked    = (state_q == LOCKED);
  assign Fault     = (state_q == FAULT);

endmodule

// File: tb/tb_gray_seq_decoder.sv
// Bench for gray_seq_decoder: two widths of wrap counter driven in lockstep,
// checked each cycle against a spec-level model plus literal spot checks.
module tb_gray_seq_decoder;

  logic       Clk = 1'b0;
  logic       Reset = 1'b0;
  logic       In_Valid = 1'b0;
  logic [2:0] Gray_In = '0;
  logic       Resync = 1'b0;

  logic       a_ov, a_of, a_uf, a_se, a_lk, a_ft;
  logic [2:0] a_bin;
  logic [7:0] a_wrap;
  logic       b_ov, b_of, b_uf, b_se, b_lk, b_ft;
  logic [2:0] b_bin;
  logic [1:0] b_wrap;

  int checks = 0;
  int errors = 0;
  bit chk = 0;

  always #5 Clk = ~Clk;

  gray_seq_decoder #(.WIDTH(3), .WRAP_W(8)) dut_a (
    .Clk(Clk), .Reset(Reset), .In_Valid(In_Valid), .Gray_In(Gray_In),
    .Resync(Resync), .Out_Valid(a_ov), .Bin_Out(a_bin), .Overflow(a_of),
    .Underflow(a_uf), .Step_Err(a_se), .Locked(a_lk), .Fault(a_ft),
    .Wrap_Cnt(a_wrap)
  );

  gray_seq_decoder #(.WIDTH(3), .WRAP_W(2)) dut_b (
    .Clk(Clk), .Reset(Reset), .In_Valid(In_Valid), .Gray_In(Gray_In),
    .Resync(Resync), .Out_Valid(b_ov), .Bin_Out(b_bin), .Overflow(b_of),
    .Underflow(b_uf), .Step_Err(b_se), .Locked(b_lk), .Fault(b_ft),
    .Wrap_Cnt(b_wrap)
  );

`ifdef GRAY_DIR_EN
  localparam bit DIR = 1'b1;
`else
  localparam bit DIR = 1'b0;
`endif

  // model state
  bit m_lock, m_fault, m_ov, m_of, m_uf, m_se;
  int m_ref, m_bin, m_w8, m_w2;

  function automatic int g2b(input int g);
    int b = 0;
    for (int i = 0; i < 3; i++) b = b ^ (g >> i);
    return b & 7;
  endfunction

  function automatic logic [2:0] b2g(input int n);
    int v = n & 7;
    return 3'(v ^ (v >> 1));
  endfunction

  always @(posedge Clk) begin
    int nb, d;
    m_ov = 0; m_of = 0; m_uf = 0; m_se = 0;
    if (Reset) begin
      m_lock = 0; m_fault = 0; m_ref = 0; m_bin = 0; m_w8 = 0; m_w2 = 0;
    end else if (Resync) begin
      m_lock = 0; m_fault = 0; m_w8 = 0; m_w2 = 0;
    end else if (In_Valid) begin
      nb = g2b(int'(Gray_In));
      d = (nb - m_ref + 8) % 8;
      m_ov = 1;
      if (m_lock) begin
        if (d == 1) begin
          if (m_ref == 7) begin
            m_of = 1;
            if (m_w8 < 255) m_w8++;
            if (m_w2 < 3) m_w2++;
          end
        end else if (d == 7 && DIR) begin
          m_uf = (m_ref == 0);
        end else if (d != 0) begin
          m_se = 1; m_lock = 0; m_fault = 1;
        end
      end else if (!m_fault) begin
        m_lock = 1;
      end
      m_ref = nb; m_bin = nb;
    end
  end

  task automatic cmp(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge Clk) begin
    if (chk) begin
      cmp("a_valid", int'(a_ov), int'(m_ov));
      cmp("a_bin", int'(a_bin), m_bin);
      cmp("a_ovf", int'(a_of), int'(m_of));
      cmp("a_unf", int'(a_uf), int'(m_uf));
      cmp("a_err", int'(a_se), int'(m_se));
      cmp("a_lock", int'(a_lk), int'(m_lock));
      cmp("a_fault", int'(a_ft), int'(m_fault));
      cmp("a_wrap", int'(a_wrap), m_w8);
      cmp("b_valid", int'(b_ov), int'(m_ov));
      cmp("b_bin", int'(b_bin), m_bin);
      cmp("b_ovf", int'(b_of), int'(m_of));
      cmp("b_err", int'(b_se), int'(m_se));
      cmp("b_lock", int'(b_lk), int'(m_lock));
      cmp("b_wrap", int'(b_wrap), m_w2);
    end
  end

  task automatic drive(input bit rst, input bit vld, input bit rs,
                       input logic [2:0] g);
    @(negedge Clk);
    Reset = rst; In_Valid = vld; Resync = rs; Gray_In = g;
    @(posedge Clk);
    #1;
  endtask

  task automatic samp(input logic [2:0] g);
    drive(0, 1, 0, g);
  endtask

  task automatic resync();
    drive(0, 0, 1, 3'b000);
  endtask

  initial begin
    logic [2:0] seq [9];
    seq = '{3'b000, 3'b001, 3'b011, 3'b010, 3'b110,
            3'b111, 3'b101, 3'b100, 3'b000};

    drive(1, 0, 0, 3'b000);
    chk = 1;
    drive(1, 1, 0, 3'b111);
    cmp("rst_bin", int'(a_bin), 0);
    cmp("rst_valid", int'(a_ov), 0);
    cmp("rst_lock", int'(a_lk), 0);
    cmp("rst_wrap", int'(a_wrap), 0);

    // full up cycle with one wrap
    for (int i = 0; i < 9; i++) begin
      samp(seq[i]);
      cmp("seq_bin", int'(a_bin), i % 8);
      cmp("seq_lock", int'(a_lk), 1);
    end
    cmp("seq_ovf", int'(a_of), 1);
    cmp("seq_wrap", int'(a_wrap), 1);

    // illegal jump into FAULT, then recover
    resync();
    samp(3'b001);
    samp(3'b010);
    cmp("jump_err", int'(a_se), 1);
    cmp("jump_bin", int'(a_bin), 3);
    cmp("jump_fault", int'(a_ft), 1);
    samp(3'b110);
    cmp("flt_bin", int'(a_bin), 4);
    cmp("flt_err", int'(a_se), 0);
    resync();
    samp(3'b110);
    cmp("rsy_lock", int'(a_lk), 1);
    cmp("rsy_fault", int'(a_ft), 0);

    // repeats and idle hold
    resync();
    samp(3'b011);
    samp(3'b011);
    cmp("rep_valid", int'(a_ov), 1);
    samp(3'b011);
    cmp("rep_bin", int'(a_bin), 2);
    cmp("rep_err", int'(a_se), 0);
    for (int i = 0; i < 5; i++) drive(0, 0, 0, 3'b101);
    cmp("idle_valid", int'(a_ov), 0);
    cmp("idle_bin", int'(a_bin), 2);
    cmp("idle_lock", int'(a_lk), 1);

    // down-step 0 -> 7
    resync();
    samp(3'b000);
    samp(3'b100);
    cmp("dn_bin", int'(a_bin), 7);
    cmp("dn_unf", int'(a_uf), int'(DIR));
    cmp("dn_err", int'(a_se), int'(!DIR));
    cmp("dn_lock", int'(a_lk), int'(DIR));

    // four full wraps saturate the narrow counter
    resync();
    samp(3'b000);
    for (int k = 1; k <= 32; k++) samp(b2g(k));
    cmp("sat_w2", int'(b_wrap), 3);
    cmp("sat_w8", int'(a_wrap), 4);
    drive(0, 1, 1, 3'b001);
    cmp("rsv_valid", int'(a_ov), 0);
    cmp("rsv_wrap", int'(b_wrap), 0);
    cmp("rsv_lock", int'(a_lk), 0);
    cmp("rsv_bin", int'(a_bin), 0);

    // reset while in FAULT
    samp(3'b000);
    samp(3'b011);
    cmp("pre_fault", int'(a_ft), 1);
    drive(1, 1, 0, 3'b111);
    cmp("mrst_bin", int'(a_bin), 0);
    cmp("mrst_wrap", int'(a_wrap), 0);
    cmp("mrst_lock", int'(a_lk), 0);
    cmp("mrst_fault", int'(a_ft), 0);
    samp(3'b101);
    cmp("post_lock", int'(a_lk), 1);
    cmp("post_bin", int'(a_bin), 6);
    cmp("post_err", int'(a_se), 0);

    drive(0, 0, 0, 3'b000);
    chk = 0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
